// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit: funct3
//               access sizes, FSM state encoding and trap cause codes.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Access FSM states
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_t;

  // Trap cause codes reported with o_done
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  // Unsigned variants only make sense for loads; 011 and 11x are not accesses.
  function automatic logic lsu_f3_illegal(input logic [2:0] f3, input logic is_store);
    case (f3)
      LSU_B, LSU_H, LSU_W: return 1'b0;
      LSU_BU, LSU_HU:      return is_store;
      default:             return 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic. Store side builds the byte mask,
//               lane-shifts the store data and flags misalignment. Load side
//               shifts the returned word down and sign/zero-extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_mask,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  input  logic [1:0]  i_ld_off,
  input  logic [2:0]  i_ld_funct3,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  // Store side: size comes from funct3[1:0]; unsigned variants share b/h lanes
  always_comb begin
    o_mask       = 4'b1111;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    case (i_funct3[1:0])
      2'b00: begin
        o_mask  = 4'b0001 << i_off;
        o_wdata = {24'b0, i_wdata[7:0]} << {i_off, 3'b000};
      end
      2'b01: begin
        o_mask       = 4'b0011 << i_off;
        o_wdata      = {16'b0, i_wdata[15:0]} << {i_off, 3'b000};
        o_misaligned = i_off[0];
      end
      default: begin
        o_misaligned = |i_off;
      end
    endcase
  end

  assign w_shifted = i_rdata >> {i_ld_off, 3'b000};

  // Load side: bring the addressed lane to bit 0, then extend from bit 7 or 15
  always_comb begin
    o_rdata = w_shifted;
    case (i_ld_funct3)
      LSU_B:   o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LSU_H:   o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LSU_BU:  o_rdata = {24'b0, w_shifted[7:0]};
      LSU_HU:  o_rdata = {16'b0, w_shifted[15:0]};
      default: o_rdata = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Data-memory access unit. Accepts one pipeline request at a
//               time, issues it on a valid/ready bus with variable-latency
//               rvalid response, and reports completion or a trap on o_done.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [3:0]  o_mem_mask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  // Counter value of the last cycle before the timeout fires
  localparam logic [CNT_W-1:0] c_TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  lsu_state_t  r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [29:0] r_addr;
  logic [3:0]  r_mask;
  logic [31:0] r_wdata;
  logic        r_ren, r_wen;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [1:0]  r_cause;
  logic [31:0] r_rdata;

  logic        w_accept, w_capture, w_timeout, w_to_hit, w_misaligned, w_illegal;
  logic [1:0]  w_req_cause;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata, w_rdata_ext;

  lsu_align u_align (
    .i_off        (i_addr[1:0]),
    .i_funct3     (i_funct3),
    .i_wdata      (i_wdata),
    .o_mask       (w_mask),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned),
    .i_ld_off     (r_off),
    .i_ld_funct3  (r_funct3),
    .i_rdata      (i_mem_rdata),
    .o_rdata      (w_rdata_ext)
  );

  // Requests with neither load nor store are dropped without leaving IDLE
  assign w_accept    = i_valid && (r_state == LSU_IDLE) && (i_load || i_store);
  assign w_illegal   = (i_load && i_store) || lsu_f3_illegal(i_funct3, i_store);
  assign w_req_cause = w_illegal ? CAUSE_ILLEGAL : (w_misaligned ? CAUSE_MISALIGN : CAUSE_NONE);
  assign w_to_hit    = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= LSU_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs; bus events on the timeout cycle win
  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    o_ready     = 1'b0;
    o_done      = 1'b0;
    o_mem_valid = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        o_ready = 1'b1;
        if (w_accept) w_next = (w_req_cause == CAUSE_NONE) ? LSU_REQ : LSU_RESP;
      end
      LSU_REQ: begin
        o_mem_valid = 1'b1;
        if (i_mem_ready) begin
          if (r_wen) begin
            w_next = LSU_RESP;
          end else if (i_mem_rvalid) begin
            w_next    = LSU_RESP;
            w_capture = 1'b1;
          end else begin
            w_next = LSU_WAIT;
          end
        end else if (w_to_hit) begin
          w_next    = LSU_RESP;
          w_timeout = 1'b1;
        end
      end
      LSU_WAIT: begin
        if (i_mem_rvalid) begin
          w_next    = LSU_RESP;
          w_capture = 1'b1;
        end else if (w_to_hit) begin
          w_next    = LSU_RESP;
          w_timeout = 1'b1;
        end
      end
      LSU_RESP: begin
        o_done = 1'b1;
        w_next = LSU_IDLE;
      end
      default: w_next = LSU_IDLE;
    endcase
  end

  // Timeout counter: restarts at acceptance, runs while the bus is busy
  always_ff @(posedge i_clk) begin
    if (i_rst)                                          r_cnt <= '0;
    else if (w_accept)                                  r_cnt <= '0;
    else if (r_state == LSU_REQ || r_state == LSU_WAIT) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Request capture and load-result register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr   <= '0;
      r_mask   <= '0;
      r_wdata  <= '0;
      r_ren    <= 1'b0;
      r_wen    <= 1'b0;
      r_funct3 <= '0;
      r_off    <= '0;
      r_cause  <= CAUSE_NONE;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= i_addr[31:2];
        r_mask   <= w_mask;
        r_wdata  <= w_wdata;
        r_ren    <= i_load  && (w_req_cause == CAUSE_NONE);
        r_wen    <= i_store && (w_req_cause == CAUSE_NONE);
        r_funct3 <= i_funct3;
        r_off    <= i_addr[1:0];
        r_cause  <= w_req_cause;
        r_rdata  <= '0;
      end
      if (w_capture) r_rdata <= w_rdata_ext;
      if (w_timeout) r_cause <= CAUSE_TIMEOUT;
    end
  end

  assign o_mem_addr   = {r_addr, 2'b00};
  assign o_mem_mask   = r_mask;
  assign o_mem_wdata  = r_wdata;
  assign o_mem_ren    = o_mem_valid && r_ren;
  assign o_mem_wen    = o_mem_valid && r_wen;
  assign o_trap       = o_done && (r_cause != CAUSE_NONE);
  assign o_trap_cause = o_done ? r_cause : CAUSE_NONE;
  assign o_rdata      = o_done ? r_rdata : 32'b0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench. Two units share the stimulus (timeouts
//               of 8 and 4); one is observed at a time. Expectations come from
//               an arithmetic model of size, offset, latency and cause.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0, i_load = 1'b0, i_store = 1'b0;
  logic [2:0]  i_funct3 = 3'b0;
  logic [31:0] i_addr = 32'b0, i_wdata = 32'b0, i_mem_rdata = 32'b0;
  logic        i_mem_ready = 1'b0, i_mem_rvalid = 1'b0;

  logic        rdy_a, done_a, trap_a, mv_a, ren_a, wen_a;
  logic [31:0] rd_a, ma_a, mw_a;
  logic [1:0]  cs_a;
  logic [3:0]  mm_a;
  logic        rdy_b, done_b, trap_b, mv_b, ren_b, wen_b;
  logic [31:0] rd_b, ma_b, mw_b;
  logic [1:0]  cs_b;
  logic [3:0]  mm_b;

  always #5 i_clk = ~i_clk;

  load_store_unit #(.TIMEOUT(8), .CNT_W(8)) u_dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(rdy_a),
    .i_load(i_load), .i_store(i_store), .i_funct3(i_funct3), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_done(done_a), .o_rdata(rd_a), .o_trap(trap_a),
    .o_trap_cause(cs_a), .o_mem_valid(mv_a), .i_mem_ready(i_mem_ready),
    .o_mem_addr(ma_a), .o_mem_ren(ren_a), .o_mem_wen(wen_a), .o_mem_mask(mm_a),
    .o_mem_wdata(mw_a), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata));

  load_store_unit #(.TIMEOUT(4), .CNT_W(8)) u_dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(rdy_b),
    .i_load(i_load), .i_store(i_store), .i_funct3(i_funct3), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_done(done_b), .o_rdata(rd_b), .o_trap(trap_b),
    .o_trap_cause(cs_b), .o_mem_valid(mv_b), .i_mem_ready(i_mem_ready),
    .o_mem_addr(ma_b), .o_mem_ren(ren_b), .o_mem_wen(wen_b), .o_mem_mask(mm_b),
    .o_mem_wdata(mw_b), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata));

  // Observed unit: 0 -> TIMEOUT 8, 1 -> TIMEOUT 4
  bit sel = 1'b0;
  wire        ob_rdy  = sel ? rdy_b  : rdy_a;
  wire        ob_done = sel ? done_b : done_a;
  wire        ob_trap = sel ? trap_b : trap_a;
  wire        ob_mv   = sel ? mv_b   : mv_a;
  wire        ob_ren  = sel ? ren_b  : ren_a;
  wire        ob_wen  = sel ? wen_b  : wen_a;
  wire [31:0] ob_rd   = sel ? rd_b   : rd_a;
  wire [31:0] ob_ma   = sel ? ma_b   : ma_a;
  wire [31:0] ob_mw   = sel ? mw_b   : mw_a;
  wire [1:0]  ob_cs   = sel ? cs_b   : cs_a;
  wire [3:0]  ob_mm   = sel ? mm_b   : mm_a;

  int n_cmp = 0, n_bad = 0;

  // Results of the last run_access
  int          res_lat, res_ndone, res_req;
  logic [31:0] res_rd, res_ma, res_mw;
  logic [3:0]  res_mm;
  logic [1:0]  res_cs;
  logic        res_tr, res_ren, res_wen, res_rdy_done;
  bit          res_memv, res_stable, res_both;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [1:0] m_cause(input bit ld, input bit st, input logic [2:0] f3,
                                         input logic [31:0] addr);
    if (ld && st) return 2'd3;
    if (f3 == 3'd3 || f3 >= 3'd6) return 2'd3;
    if (st && f3 >= 3'd4) return 2'd3;
    if (int'(addr[1:0]) % m_size(f3) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] addr);
    return 4'(((1 << m_size(f3)) - 1) << int'(addr[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] wd);
    longint v = {32'b0, wd} % (64'd1 << (8 * m_size(f3)));
    return 32'(v << (8 * int'(addr[1:0])));
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int     sz = m_size(f3);
    longint v  = ({32'b0, rd} >> (8 * int'(addr[1:0]))) % (64'd1 << (8 * sz));
    if (f3 < 3'd4 && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    return 32'(v);
  endfunction

  // Expected completion sample, cause and result for a given memory behaviour
  task automatic m_expect(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rd,
                          input int rdy, input int rv, input int tmo,
                          output int lat, output logic [1:0] cs, output logic [31:0] exp_rd,
                          output bit memv);
    int busy;
    cs = m_cause(ld, st, f3, addr);
    exp_rd = 32'b0;
    memv = 1'b0;
    lat = 1;
    if (cs != 2'd0) return;
    memv = 1'b1;
    busy = rdy + 1 + ((ld && rv > 0) ? rv : 0);
    if (tmo != 0 && busy > tmo) begin
      lat = tmo + 1;
      cs  = 2'd2;
    end else begin
      lat = busy + 1;
      if (ld) exp_rd = m_load(f3, addr, rd);
    end
  endtask

  // ---------------- stimulus driver + memory responder ----------------
  task automatic wait_both_ready();
    int guard = 0;
    @(negedge i_clk);
    while (!(rdy_a && rdy_b) && guard < 50) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_ready: units still busy after %0d cycles", guard);
    end
  endtask

  task automatic run_access(input bit ld, input bit st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int rdy, input int rv);
    bit first = 1'b1, acc = 1'b0;
    int since = 0;
    wait_both_ready();
    i_valid = 1'b1; i_load = ld; i_store = st; i_funct3 = f3;
    i_addr = addr; i_wdata = wd; i_mem_rdata = rd;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    res_lat = 0; res_ndone = 0; res_req = 0; res_memv = 0; res_stable = 1; res_both = 0;
    res_rd = 'x; res_tr = 'x; res_cs = 'x; res_rdy_done = 'x;
    res_ma = 'x; res_mm = 'x; res_mw = 'x; res_ren = 'x; res_wen = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge i_clk);
      i_valid = 1'b0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
      if (ob_done) begin
        res_ndone++;
        if (res_lat == 0) begin
          res_lat = k; res_rd = ob_rd; res_tr = ob_trap; res_cs = ob_cs; res_rdy_done = ob_rdy;
        end
      end
      if (ob_ren && ob_wen) res_both = 1'b1;
      if (ob_mv) begin
        res_memv = 1'b1;
        res_req++;
        if (first) begin
          res_ma = ob_ma; res_mm = ob_mm; res_mw = ob_mw; res_ren = ob_ren; res_wen = ob_wen;
          first = 1'b0;
        end else if (ob_ma !== res_ma || ob_mm !== res_mm || ob_mw !== res_mw ||
                     ob_ren !== res_ren || ob_wen !== res_wen) begin
          res_stable = 1'b0;
        end
        if (res_req > rdy) begin
          i_mem_ready = 1'b1;
          acc = 1'b1;
          if (ld && rv == 0) i_mem_rvalid = 1'b1;
        end
      end else if (acc && ld && res_lat == 0) begin
        since++;
        if (since == rv) i_mem_rvalid = 1'b1;
      end
      if (res_lat != 0 && k >= res_lat + 2) break;
    end
    i_valid = 1'b0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    n_cmp++; if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", rdy_a); end
    n_cmp++; if ({done_a, trap_a, mv_a, ren_a, wen_a} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {done_a, trap_a, mv_a, ren_a, wen_a}); end
    n_cmp++; if (rd_a !== 32'h0 || cs_a !== 2'b00) begin
      n_bad++; $display("FAIL reset_data: rdata %h cause %b want 0/00", rd_a, cs_a); end
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || mv_a !== 1'b0) begin
      n_bad++; $display("FAIL post_reset: ready %b%b memv %b want 11/0", rdy_a, rdy_b, mv_a); end
  endtask

  task automatic test_sb();
    sel = 1'b0;
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00AB, 32'h0, 0, 0);
    n_cmp++; if (res_ma !== 32'h0000_2000) begin n_bad++; $display("FAIL sb_addr: got %h want 00002000", res_ma); end
    n_cmp++; if (res_mm !== 4'b1000) begin n_bad++; $display("FAIL sb_mask: got %b want 1000", res_mm); end
    n_cmp++; if (res_mw !== 32'hAB00_0000) begin n_bad++; $display("FAIL sb_wdata: got %h want ab000000", res_mw); end
    n_cmp++; if (res_wen !== 1'b1 || res_ren !== 1'b0) begin
      n_bad++; $display("FAIL sb_wen: wen %b ren %b want 1/0", res_wen, res_ren); end
    n_cmp++; if (res_lat !== 2 || res_tr !== 1'b0) begin
      n_bad++; $display("FAIL sb_done: latency %0d trap %b want 2/0", res_lat, res_tr); end
    n_cmp++; if (res_ndone !== 1 || res_rdy_done !== 1'b0) begin
      n_bad++; $display("FAIL sb_pulse: dones %0d ready_in_resp %b want 1/0", res_ndone, res_rdy_done); end
  endtask

  task automatic test_lh();
    sel = 1'b0;
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h8001_1234, 0, 1);
    n_cmp++; if (res_mm !== 4'b1100 || res_ren !== 1'b1) begin
      n_bad++; $display("FAIL lh_mask: mask %b ren %b want 1100/1", res_mm, res_ren); end
    n_cmp++; if (res_rd !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_rdata: got %h want ffff8001", res_rd); end
    run_access(1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'h8001_1234, 0, 0);
    n_cmp++; if (res_rd !== 32'h0000_8001 || res_lat !== 2) begin
      n_bad++; $display("FAIL lhu_rdata: got %h lat %0d want 00008001/2", res_rd, res_lat); end
  endtask

  task automatic test_misalign();
    sel = 1'b0;
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_1001, 32'h0, 32'hDEAD_BEEF, 0, 0);
    n_cmp++; if (res_lat !== 1 || res_tr !== 1'b1 || res_cs !== 2'b01) begin
      n_bad++; $display("FAIL lw_misalign: lat %0d trap %b cause %b want 1/1/01", res_lat, res_tr, res_cs); end
    n_cmp++; if (res_memv !== 1'b0 || res_rd !== 32'h0) begin
      n_bad++; $display("FAIL lw_misalign_bus: memv %b rdata %h want 0/0", res_memv, res_rd); end
  endtask

  task automatic test_illegal();
    logic [2:0] f3s [4] = '{3'b010, 3'b100, 3'b011, 3'b110};
    bit         lds [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit         sts [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_access(lds[i], sts[i], f3s[i], 32'h0000_0100, 32'h1234_5678, 32'h0, 0, 0);
      n_cmp++; if (res_lat !== 1 || res_cs !== 2'b11 || res_memv !== 1'b0) begin
        n_bad++; $display("FAIL illegal_%0d: lat %0d cause %b memv %b want 1/11/0", i, res_lat, res_cs, res_memv); end
    end
  endtask

  task automatic test_slow_load();
    logic [31:0] rd = $urandom;
    sel = 1'b0;
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_3001, 32'h0, rd, 5, 2);
    n_cmp++; if (res_stable !== 1'b1 || res_req !== 6) begin
      n_bad++; $display("FAIL slow_stable: stable %b req_cycles %0d want 1/6", res_stable, res_req); end
    n_cmp++; if (res_ma !== 32'h0000_3000 || res_mm !== 4'b0010) begin
      n_bad++; $display("FAIL slow_addr: addr %h mask %b want 00003000/0010", res_ma, res_mm); end
    n_cmp++; if (res_rd !== m_load(3'b000, 32'h3001, rd) || res_tr !== 1'b0 || res_lat !== 9) begin
      n_bad++; $display("FAIL slow_rdata: got %h trap %b lat %0d want %h/0/9", res_rd, res_tr, res_lat,
                        m_load(3'b000, 32'h3001, rd)); end
  endtask

  task automatic test_timeout();
    int late = 0;
    sel = 1'b1;
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h5555_AAAA, 1000, 0);
    n_cmp++; if (res_lat !== 5 || res_tr !== 1'b1 || res_cs !== 2'b10) begin
      n_bad++; $display("FAIL to4_done: lat %0d trap %b cause %b want 5/1/10", res_lat, res_tr, res_cs); end
    n_cmp++; if (res_req !== 4 || res_rd !== 32'h0) begin
      n_bad++; $display("FAIL to4_bus: req_cycles %0d rdata %h want 4/0", res_req, res_rd); end
    i_mem_rvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      if (k == 1) i_mem_rvalid = 1'b0;
      if (done_b) late++;
    end
    i_mem_rvalid = 1'b0;
    n_cmp++; if (late !== 0) begin n_bad++; $display("FAIL to4_stray: dones %0d want 0", late); end
    sel = 1'b0;
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_5000, 32'h0BAD_F00D, 32'h0, 7, 0);
    n_cmp++; if (res_lat !== 9 || res_cs !== 2'b00) begin
      n_bad++; $display("FAIL to8_edge_win: lat %0d cause %b want 9/00", res_lat, res_cs); end
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_5000, 32'h0BAD_F00D, 32'h0, 8, 0);
    n_cmp++; if (res_lat !== 9 || res_cs !== 2'b10) begin
      n_bad++; $display("FAIL to8_expire: lat %0d cause %b want 9/10", res_lat, res_cs); end
  endtask

  task automatic test_reset_in_wait();
    int dones = 0;
    sel = 1'b0;
    wait_both_ready();
    i_valid = 1'b1; i_load = 1'b1; i_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h6000;
    @(negedge i_clk);
    i_valid = 1'b0; i_mem_ready = 1'b1;
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    n_cmp++; if (mv_a !== 1'b0 || rdy_a !== 1'b0) begin
      n_bad++; $display("FAIL rstw_inwait: memv %b ready %b want 0/0", mv_a, rdy_a); end
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    n_cmp++; if (rdy_a !== 1'b1 || done_a !== 1'b0) begin
      n_bad++; $display("FAIL rstw_idle: ready %b done %b want 1/0", rdy_a, done_a); end
    i_mem_rvalid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      if (done_a) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rstw_nodone: dones %0d want 0", dones); end
  endtask

  task automatic test_ignored();
    wait_both_ready();
    i_valid = 1'b1; i_load = 1'b0; i_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h7000;
    @(negedge i_clk);
    i_valid = 1'b0;
    n_cmp++; if (rdy_a !== 1'b1 || mv_a !== 1'b0 || done_a !== 1'b0) begin
      n_bad++; $display("FAIL ignored: ready %b memv %b done %b want 1/0/0", rdy_a, mv_a, done_a); end
  endtask

  task automatic test_random();
    logic [2:0]  f3s [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b010, 3'b011};
    bit          ld, st, memv;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rd, erd;
    logic [1:0]  ecs;
    int          rdy, rv, elat, pick;
    sel = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 9);
      ld = (pick != 1); st = (pick <= 1) || (pick >= 6);
      if (pick >= 6) ld = 1'b0;
      f3 = f3s[$urandom_range(0, 7)];
      addr = $urandom; wd = $urandom; rd = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      rdy = $urandom_range(0, 4); rv = $urandom_range(0, 3);
      m_expect(ld, st, f3, addr, rd, rdy, rv, 8, elat, ecs, erd, memv);
      run_access(ld, st, f3, addr, wd, rd, rdy, rv);
      n_cmp++; if (res_lat !== elat || res_ndone !== 1 || res_cs !== ecs || res_tr !== (ecs != 2'b00)) begin
        n_bad++; $display("FAIL rnd%0d_done: lat %0d n %0d cause %b trap %b want %0d/1/%b/%b",
                          i, res_lat, res_ndone, res_cs, res_tr, elat, ecs, ecs != 2'b00); end
      n_cmp++; if (res_rd !== erd) begin
        n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h", i, res_rd, erd); end
      n_cmp++; if (res_memv !== memv || res_both !== 1'b0) begin
        n_bad++; $display("FAIL rnd%0d_memv: memv %b both %b want %b/0", i, res_memv, res_both, memv); end
      if (memv) begin
        n_cmp++; if (res_ma !== {addr[31:2], 2'b00} || res_mm !== m_mask(f3, addr) ||
                     res_ren !== ld || res_wen !== st || res_stable !== 1'b1) begin
          n_bad++; $display("FAIL rnd%0d_bus: addr %h mask %b r/w %b%b stable %b want %h/%b/%b%b/1", i,
                            res_ma, res_mm, res_ren, res_wen, res_stable, {addr[31:2], 2'b00},
                            m_mask(f3, addr), ld, st); end
        if (st) begin
          n_cmp++; if (res_mw !== m_wdata(f3, addr, wd)) begin
            n_bad++; $display("FAIL rnd%0d_wdata: got %h want %h", i, res_mw, m_wdata(f3, addr, wd)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_lh();
    test_misalign();
    test_illegal();
    test_slow_load();
    test_timeout();
    test_reset_in_wait();
    test_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
